// File: rtl/frame_out_scheduler.sv
// Frame output scheduler: caches one header per input FIFO, arbitrates between
// cached ports (strict priority or round robin), streams the granted frame's
// payload downstream and checks a CRC-32 over the payload against the header.
//
// Ports:
//   clk, rst_n     clock; reset (asynchronous, active-high)
//   fifo_empty     per-port FIFO empty flags
//   fifo_data      word of FIFO rd_sel, valid the cycle after rd_en
//   rd_en, rd_sel  FIFO pop strobe and port select (rd_sel=0 when idle)
//   ready          downstream can take a word in the next cycle
//   qos_mode       0 = strict priority, 1 = round robin
//   out_data/out_vld/out_sop/out_eop  frame stream
//   crc_err, err_port  CRC mismatch pulse and port of last mismatch
//   drop           zero-length frame pulse
module frame_out_scheduler #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PORT_NUM   = 16,
  parameter int unsigned PRI_WIDTH  = 3,
  parameter int unsigned LEN_WIDTH  = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORT_NUM-1:0]         fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        rd_en,
  output logic [$clog2(PORT_NUM)-1:0] rd_sel,
  input  logic                        ready,
  input  logic                        qos_mode,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_vld,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic                        crc_err,
  output logic [$clog2(PORT_NUM)-1:0] err_port,
  output logic                        drop
);

  localparam int unsigned PORT_W  = $clog2(PORT_NUM);
  localparam int unsigned CRC_LSB = PRI_WIDTH;
  localparam int unsigned LEN_LSB = PRI_WIDTH + 32;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  typedef enum logic [2:0] {IDLE, HDR_RD, HDR_CAP, ARB, SEND, CHECK} state_t;

  state_t                state, state_d;
  logic [PORT_W-1:0]     sp, sp_d, rr_ptr, rr_d, grant, grant_d;
  logic [LEN_WIDTH-1:0]  rem, rem_d;
  logic                  first, first_d;
  logic [31:0]           crc, crc_d, crc_nxt;
  logic                  out_vld_d, out_sop_d, out_eop_d, crc_err_d, drop_d;
  logic [PORT_W-1:0]     err_port_d;
  logic                  cap_en, clr_en;
  logic [PORT_W-1:0]     clr_idx;

  logic [PORT_NUM-1:0]   hdr_vld;
  logic [PRI_WIDTH-1:0]  hdr_pri [PORT_NUM];
  logic [31:0]           hdr_crc [PORT_NUM];
  logic [LEN_WIDTH-1:0]  hdr_len [PORT_NUM];

  logic                  strict_found, rr_found;
  logic [PORT_W-1:0]     strict_idx, rr_idx, rr_cand, pick;
  logic [PRI_WIDTH-1:0]  best_pri;

  // One full data word folded into the CRC, MSB first.
  function automatic logic [31:0] crc_word(input logic [31:0] c_in,
                                           input logic [DATA_WIDTH-1:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // Payload words pass straight through in the cycle after their pop.
  assign out_data = out_vld ? fifo_data : '0;
  assign crc_nxt  = crc_word(crc, fifo_data);

  // Grant candidates: highest priority (lowest index on tie) and first valid from rr_ptr.
  always_comb begin : arbitrate
    strict_found = 1'b0;
    strict_idx   = '0;
    best_pri     = '0;
    rr_found     = 1'b0;
    rr_idx       = '0;
    rr_cand      = '0;
    for (int i = 0; i < int'(PORT_NUM); i++) begin
      if (hdr_vld[i] && (!strict_found || hdr_pri[i] > best_pri)) begin
        strict_found = 1'b1;
        strict_idx   = PORT_W'(i);
        best_pri     = hdr_pri[i];
      end
    end
    for (int k = 0; k < int'(PORT_NUM); k++) begin
      rr_cand = rr_ptr + PORT_W'(k);
      if (!rr_found && hdr_vld[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
    pick = qos_mode ? rr_idx : strict_idx;
  end

  // Next-state, FIFO pop and registered-output next values.
  always_comb begin : next_state
    state_d    = state;
    sp_d       = sp;
    rr_d       = rr_ptr;
    grant_d    = grant;
    rem_d      = rem;
    first_d    = first;
    crc_d      = crc;
    out_vld_d  = 1'b0;
    out_sop_d  = 1'b0;
    out_eop_d  = 1'b0;
    crc_err_d  = 1'b0;
    err_port_d = err_port;
    drop_d     = 1'b0;
    cap_en     = 1'b0;
    clr_en     = 1'b0;
    clr_idx    = grant;
    rd_en      = 1'b0;
    rd_sel     = '0;

    if (out_vld) crc_d = crc_nxt;

    case (state)
      IDLE: begin
        if (!fifo_empty[sp] && !hdr_vld[sp]) begin
          state_d = HDR_RD;
        end else begin
          sp_d = sp + PORT_W'(1);
          if (|hdr_vld) state_d = ARB;
        end
      end
      HDR_RD: begin
        rd_en   = 1'b1;
        rd_sel  = sp;
        state_d = HDR_CAP;
      end
      HDR_CAP: begin
        cap_en  = 1'b1;
        sp_d    = sp + PORT_W'(1);
        state_d = IDLE;
      end
      ARB: begin
        grant_d = pick;
        rr_d    = pick + PORT_W'(1);
        if (hdr_len[pick] == '0) begin
          drop_d  = 1'b1;
          clr_en  = 1'b1;
          clr_idx = pick;
          state_d = IDLE;
        end else begin
          rem_d   = hdr_len[pick];
          first_d = 1'b1;
          crc_d   = CRC_INIT;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready && !fifo_empty[grant] && rem != '0) begin
          rd_en     = 1'b1;
          rd_sel    = grant;
          rem_d     = rem - LEN_WIDTH'(1);
          out_vld_d = 1'b1;
          out_sop_d = first;
          out_eop_d = (rem == LEN_WIDTH'(1));
          first_d   = 1'b0;
        end
        // The eop word is on the bus now; its CRC contribution is crc_nxt.
        if (out_vld && out_eop) begin
          if (crc_nxt != hdr_crc[grant]) begin
            crc_err_d  = 1'b1;
            err_port_d = grant;
          end
          state_d = CHECK;
        end
      end
      CHECK: begin
        clr_en  = 1'b1;
        crc_d   = CRC_INIT;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and header cache registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      sp       <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
      rem      <= '0;
      first    <= 1'b0;
      crc      <= CRC_INIT;
      out_vld  <= 1'b0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      crc_err  <= 1'b0;
      err_port <= '0;
      drop     <= 1'b0;
      hdr_vld  <= '0;
      for (int i = 0; i < int'(PORT_NUM); i++) begin
        hdr_pri[i] <= '0;
        hdr_crc[i] <= '0;
        hdr_len[i] <= '0;
      end
    end else begin
      state    <= state_d;
      sp       <= sp_d;
      rr_ptr   <= rr_d;
      grant    <= grant_d;
      rem      <= rem_d;
      first    <= first_d;
      crc      <= crc_d;
      out_vld  <= out_vld_d;
      out_sop  <= out_sop_d;
      out_eop  <= out_eop_d;
      crc_err  <= crc_err_d;
      err_port <= err_port_d;
      drop     <= drop_d;
      if (cap_en) begin
        hdr_vld[sp] <= 1'b1;
        hdr_pri[sp] <= fifo_data[PRI_WIDTH-1:0];
        hdr_crc[sp] <= fifo_data[CRC_LSB +: 32];
        hdr_len[sp] <= fifo_data[LEN_LSB +: LEN_WIDTH];
      end
      if (clr_en) hdr_vld[clr_idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_out_scheduler.sv
// Directed testbench for frame_out_scheduler: behavioural FIFOs per port,
// an output monitor, and one task per scenario with hand-derived expectations.
module tb_frame_out_scheduler;

  localparam int DW = 64;
  localparam int PN = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PN-1:0] fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          rd_en;
  logic [3:0]    rd_sel;
  logic          ready;
  logic          qos_mode;
  logic [DW-1:0] out_data;
  logic          out_vld, out_sop, out_eop, crc_err, drop;
  logic [3:0]    err_port;

  always #5 clk = ~clk;

  frame_out_scheduler dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_en(rd_en), .rd_sel(rd_sel), .ready(ready), .qos_mode(qos_mode),
    .out_data(out_data), .out_vld(out_vld), .out_sop(out_sop), .out_eop(out_eop),
    .crc_err(crc_err), .err_port(err_port), .drop(drop)
  );

  // Behavioural input FIFOs
  logic [DW-1:0] mem [PN][256];
  int            wr_ptr [PN];
  int            rd_ptr [PN];
  logic [PN-1:0] force_empty;
  logic          flush;
  int            cyc;

  always_comb begin
    for (int p = 0; p < PN; p++)
      fifo_empty[p] = (rd_ptr[p] == wr_ptr[p]) || force_empty[p];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) begin
      for (int p = 0; p < PN; p++) rd_ptr[p] <= wr_ptr[p];
    end else if (rd_en) begin
      fifo_data      <= mem[rd_sel][8'(rd_ptr[rd_sel])];
      rd_ptr[rd_sel] <= rd_ptr[rd_sel] + 1;
    end
  end

  // Output monitor
  logic [DW-1:0] got_data [$];
  bit            got_sop [$];
  bit            got_eop [$];
  int            got_cyc [$];
  int            err_cnt, err_cyc, drop_cnt, rd_no_ready, late_words, rdsel_viol;
  logic [3:0]    err_port_seen;
  logic          ready_q = 1'b1;

  always @(negedge clk) begin
    if (out_vld) begin
      got_data.push_back(out_data);
      got_sop.push_back(out_sop);
      got_eop.push_back(out_eop);
      got_cyc.push_back(cyc);
    end
    if (crc_err) begin
      err_cnt++;
      err_cyc       = cyc;
      err_port_seen = err_port;
    end
    if (drop) drop_cnt++;
    if (rd_en && !ready) rd_no_ready++;
    if (out_vld && !ready_q) late_words++;
    if (!rd_en && rd_sel != 4'd0) rdsel_viol++;
    ready_q = ready;
  end

  // Expected stream
  logic [DW-1:0] exp_data [$];
  bit            exp_sop [$];
  bit            exp_eop [$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] crc32_step(input logic [31:0] c_in, input logic [63:0] d);
    logic [31:0] c;
    bit          fb;
    c = c_in;
    for (int b = 63; b >= 0; b--) begin
      fb = c[31] ^ d[b];
      c  = c << 1;
      if (fb) c = c ^ 32'h04C11DB7;
    end
    return c;
  endfunction

  function automatic logic [63:0] payload(input int base, input int i);
    return {16'hA5C3, 16'(base), 16'(i), 16'(base ^ (i * 7))};
  endfunction

  task automatic clear_mon();
    got_data.delete(); got_sop.delete(); got_eop.delete(); got_cyc.delete();
    exp_data.delete(); exp_sop.delete(); exp_eop.delete();
    err_cnt = 0; err_cyc = 0; drop_cnt = 0; rd_no_ready = 0; late_words = 0; rdsel_viol = 0;
  endtask

  // Header + payload into port p's FIFO; payload appended to the expected stream.
  task automatic push_frame(input int p, input int pri, input int len, input bit bad, input int base);
    logic [31:0] c;
    logic [63:0] h;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) c = crc32_step(c, payload(base, i));
    if (bad) c = c ^ 32'h1;
    h = (64'(len) << 35) | (64'(c) << 3) | 64'(pri);
    mem[p][8'(wr_ptr[p])] = h;
    for (int i = 0; i < len; i++) begin
      mem[p][8'(wr_ptr[p] + 1 + i)] = payload(base, i);
      exp_data.push_back(payload(base, i));
      exp_sop.push_back(i == 0);
      exp_eop.push_back(i == len - 1);
    end
    wr_ptr[p] = wr_ptr[p] + len + 1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (got_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({rd_en, rd_sel} !== 5'd0) begin
      n_fail++; $display("FAIL reset_rd: got %b expected 0", {rd_en, rd_sel});
    end
    n_checks++;
    if ({out_data, out_vld, out_sop, out_eop} !== 67'd0) begin
      n_fail++; $display("FAIL reset_out: got data=%h vld/sop/eop=%b%b%b expected 0", out_data, out_vld, out_sop, out_eop);
    end
    n_checks++;
    if ({crc_err, err_port, drop} !== 6'd0) begin
      n_fail++; $display("FAIL reset_err: got crc_err=%b err_port=%0d drop=%b expected 0", crc_err, err_port, drop);
    end
    rst_n = 1'b0;
    step(2);
  endtask

  task automatic test_single_frame();
    bit ok;
    clear_mon();
    push_frame(3, 2, 4, 1'b0, 1);
    wait_words(4, 200, ok);
    step(8);
    n_checks++;
    if (!ok || got_data.size() != 4) begin
      n_fail++; $display("FAIL single_count: got %0d words expected 4", got_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        n_fail++; $display("FAIL single_word%0d: got %h expected %h (sop/eop exp %b%b)", i, (i < got_data.size()) ? got_data[i] : 64'hx, exp_data[i], exp_sop[i], exp_eop[i]);
      end
    end
    n_checks++;
    if (got_data.size() == 4 && got_cyc[3] - got_cyc[0] != 3) begin
      n_fail++; $display("FAIL single_consecutive: span %0d expected 3", got_cyc[3] - got_cyc[0]);
    end
    n_checks++;
    if (err_cnt != 0 || rdsel_viol != 0) begin
      n_fail++; $display("FAIL single_err: crc_err pulses %0d rd_sel violations %0d expected 0/0", err_cnt, rdsel_viol);
    end
  endtask

  task automatic test_strict_priority();
    bit ok;
    clear_mon();
    qos_mode = 1'b0;
    push_frame(5, 6, 3, 1'b0, 50);
    push_frame(1, 1, 2, 1'b0, 10);
    push_frame(2, 0, 0, 1'b0, 0);
    push_frame(3, 0, 0, 1'b0, 0);
    push_frame(4, 0, 0, 1'b0, 0);
    wait_words(5, 400, ok);
    step(40);
    n_checks++;
    if (!ok || got_data.size() != 5) begin
      n_fail++; $display("FAIL strict_count: got %0d words expected 5", got_data.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        n_fail++; $display("FAIL strict_word%0d: got %h expected %h", i, (i < got_data.size()) ? got_data[i] : 64'hx, exp_data[i]);
      end
    end
    n_checks++;
    if (drop_cnt != 3 || err_cnt != 0) begin
      n_fail++; $display("FAIL strict_drop: drops %0d crc_err %0d expected 3/0", drop_cnt, err_cnt);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    rst_n = 1'b1;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    clear_mon();
    qos_mode = 1'b1;
    push_frame(1, 1, 2, 1'b0, 20);
    push_frame(5, 6, 3, 1'b0, 60);
    push_frame(2, 0, 0, 1'b0, 0);
    push_frame(3, 0, 0, 1'b0, 0);
    push_frame(4, 0, 0, 1'b0, 0);
    step(1);
    rst_n = 1'b0;
    wait_words(5, 400, ok);
    step(20);
    n_checks++;
    if (!ok || got_data.size() != 5) begin
      n_fail++; $display("FAIL rr_count: got %0d words expected 5", got_data.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        n_fail++; $display("FAIL rr_word%0d: got %h expected %h", i, (i < got_data.size()) ? got_data[i] : 64'hx, exp_data[i]);
      end
    end
    n_checks++;
    if (drop_cnt != 3) begin
      n_fail++; $display("FAIL rr_drop: drops %0d expected 3", drop_cnt);
    end
    qos_mode = 1'b0;
  endtask

  task automatic test_crc_error();
    bit ok;
    clear_mon();
    push_frame(0, 4, 3, 1'b1, 30);
    wait_words(3, 300, ok);
    step(6);
    n_checks++;
    if (!ok || got_data.size() != 3) begin
      n_fail++; $display("FAIL crc_count: got %0d words expected 3", got_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_eop[i] !== exp_eop[i]) begin
        n_fail++; $display("FAIL crc_word%0d: got %h expected %h", i, (i < got_data.size()) ? got_data[i] : 64'hx, exp_data[i]);
      end
    end
    n_checks++;
    if (err_cnt != 1) begin
      n_fail++; $display("FAIL crc_pulse: crc_err pulses %0d expected 1", err_cnt);
    end
    n_checks++;
    if (got_cyc.size() == 3 && (err_cyc != got_cyc[2] + 1 || err_port_seen !== 4'd0)) begin
      n_fail++; $display("FAIL crc_timing: err at cycle %0d port %0d expected cycle %0d port 0", err_cyc, err_port_seen, got_cyc[2] + 1);
    end
    clear_mon();
    push_frame(6, 3, 2, 1'b0, 31);
    wait_words(2, 300, ok);
    step(6);
    n_checks++;
    if (!ok || got_data.size() != 2 || got_data[0] !== exp_data[0] || got_data[1] !== exp_data[1] || err_cnt != 0) begin
      n_fail++; $display("FAIL crc_next_frame: got %0d words, crc_err %0d expected 2 words, 0 errors", got_data.size(), err_cnt);
    end
  endtask

  task automatic test_ready_stall();
    bit ok;
    clear_mon();
    push_frame(2, 5, 8, 1'b0, 40);
    wait_words(2, 300, ok);
    ready = 1'b0;
    step(5);
    ready = 1'b1;
    wait_words(8, 300, ok);
    step(6);
    n_checks++;
    if (!ok || got_data.size() != 8) begin
      n_fail++; $display("FAIL ready_count: got %0d words expected 8", got_data.size());
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        n_fail++; $display("FAIL ready_word%0d: got %h expected %h", i, (i < got_data.size()) ? got_data[i] : 64'hx, exp_data[i]);
      end
    end
    n_checks++;
    if (rd_no_ready != 0 || late_words != 0) begin
      n_fail++; $display("FAIL ready_skid: rd_en while not ready %0d, late words %0d expected 0/0", rd_no_ready, late_words);
    end
    n_checks++;
    if (got_cyc.size() == 8 && got_cyc[7] - got_cyc[0] != 12) begin
      n_fail++; $display("FAIL ready_span: span %0d expected 12", got_cyc[7] - got_cyc[0]);
    end
  endtask

  task automatic test_empty_stall_and_drop();
    bit ok;
    clear_mon();
    push_frame(4, 1, 6, 1'b0, 70);
    wait_words(2, 300, ok);
    force_empty[4] = 1'b1;
    step(3);
    force_empty[4] = 1'b0;
    wait_words(6, 300, ok);
    step(8);
    n_checks++;
    if (!ok || got_data.size() != 6) begin
      n_fail++; $display("FAIL empty_count: got %0d words expected 6", got_data.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_eop[i] !== exp_eop[i]) begin
        n_fail++; $display("FAIL empty_word%0d: got %h expected %h", i, (i < got_data.size()) ? got_data[i] : 64'hx, exp_data[i]);
      end
    end
    n_checks++;
    if (got_cyc.size() == 6 && got_cyc[5] - got_cyc[0] != 8) begin
      n_fail++; $display("FAIL empty_span: span %0d expected 8", got_cyc[5] - got_cyc[0]);
    end
    clear_mon();
    push_frame(7, 2, 0, 1'b0, 0);
    step(40);
    n_checks++;
    if (drop_cnt != 1 || got_data.size() != 0) begin
      n_fail++; $display("FAIL drop: drops %0d words %0d expected 1/0", drop_cnt, got_data.size());
    end
    n_checks++;
    if (rd_ptr[7] != wr_ptr[7]) begin
      n_fail++; $display("FAIL drop_pop: port7 rd %0d wr %0d expected equal", rd_ptr[7], wr_ptr[7]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    clear_mon();
    push_frame(9, 3, 6, 1'b0, 90);
    wait_words(1, 300, ok);
    n_checks++;
    if (!ok || out_vld !== 1'b1 || out_sop !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_word2: vld=%b sop=%b expected 1/0", out_vld, out_sop);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({rd_en, rd_sel, out_vld, out_sop, out_eop, crc_err, drop} !== 10'd0 || out_data !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: rd_en=%b vld=%b data=%h expected 0", rd_en, out_vld, out_data);
    end
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(1);
    n_checks++;
    if (got_data.size() != 1 || got_eop[0] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_abandon: got %0d words expected 1 without eop", got_data.size());
    end
    clear_mon();
    push_frame(9, 3, 3, 1'b0, 91);
    rst_n = 1'b0;
    wait_words(3, 300, ok);
    step(8);
    n_checks++;
    if (!ok || got_data.size() != 3) begin
      n_fail++; $display("FAIL rstmid_count: got %0d words expected 3", got_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        n_fail++; $display("FAIL rstmid_word%0d: got %h expected %h", i, (i < got_data.size()) ? got_data[i] : 64'hx, exp_data[i]);
      end
    end
    n_checks++;
    if (err_cnt != 0) begin
      n_fail++; $display("FAIL rstmid_crc: crc_err pulses %0d expected 0", err_cnt);
    end
  endtask

  initial begin
    rst_n       = 1'b1;
    ready       = 1'b1;
    qos_mode    = 1'b0;
    force_empty = '0;
    flush       = 1'b0;
    step(3);
    test_reset();
    test_single_frame();
    test_strict_priority();
    test_round_robin();
    test_crc_error();
    test_ready_stall();
    test_empty_stall_and_drop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
